ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-port arbiter that shares the single-port word RAM between the instruction-fetch path and the load/store path. It accepts one request at a time, sequences it onto the RAM's write-enable/address/data lines, honours the RAM busy flag, and returns read data with a one-cycle acknowledge pulse. Data accesses have priority, and a starvation limit guarantees fetch progress. It sits between the core's fetch/LSU request ports and the RAM instance.

## Interface
- STARVE_LIMIT, 4: maximum consecutive data grants while fetch is pending; range 1..7.
- clk  in  1  clock; all state changes on the rising edge.
- nRst  in  1  reset, asynchronous, active-low.
- i_req  in  1  fetch read request; held until i_ack.
- i_addr  in  32  fetch byte address.
- i_rdata  out  32  fetch read data; valid when i_ack=1.
- i_ack  out  1  one-cycle fetch completion pulse.
- d_ren  in  1  data read request; held until d_ack.
- d_wen  in  1  data write request; held until d_ack.
- d_addr  in  32  data byte address.
- d_wdata  in  32  write data.
- d_rdata  out  32  data read data; valid when d_ack=1.
- d_ack  out  1  one-cycle data completion pulse.
- ram_wen  out  1  RAM write enable.
- ram_addr  out  32  RAM byte address, passed unchanged.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM combinational read data.
- ram_busy  in  1  RAM cannot accept an access this cycle.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If a data request is pending (d_ren|d_wen) and not (i_req && starve_cnt==STARVE_LIMIT), grant data.
  - Else, if i_req is pending, grant fetch.
  - On grant, latch owner, address, write flag and wdata, then go to ACCESS.
  - With no request, stay in IDLE.
- ACCESS:
  - Drive ram_addr and ram_wdata from the latched values.
  - If ram_busy=1, hold ram_wen=0 and stay in ACCESS.
  - Else assert ram_wen for a write, capture ram_rdata into the owner's rdata register for a read, and go to DONE.
- DONE: assert the owner's ack for exactly one cycle, then go to IDLE.
- d_wen and d_ren both high: treated as a write; d_rdata returns 0.
- A write updates only d_ack; d_rdata holds 0 for writes.
- Requests are sampled only in IDLE. A request dropped mid-access still completes and still pulses ack.
- Starvation counter (3 bits):
  - Increments on a data grant made while i_req=1.
  - Clears on a fetch grant, or whenever in IDLE with i_req=0.
  - Saturates at STARVE_LIMIT.
- Addresses are not checked for alignment; the RAM applies the word index.

## Timing
- Reset (async, nRst=0): state=IDLE; i_ack, d_ack, ram_wen=0; i_rdata, d_rdata, ram_addr, ram_wdata=0; starve_cnt=0; latched request cleared.
- Latency with no busy: request seen in IDLE at cycle N, RAM access at N+1, ack and rdata at N+2. Next grant is evaluated at N+3.
- Peak throughput: one access per 3 cycles.
- Each cycle of ram_busy in ACCESS adds one cycle of latency.
- ram_wen is high for at most one cycle per write, and only in ACCESS with ram_busy=0.
- Outside ACCESS, ram_wen=0 and ram_addr/ram_wdata hold their last values.
- Reset asserted mid-access: the access is abandoned, no ack is issued, and no write occurs after reset.

## Structure
- Package ram_arb_pkg holds:
  - typedef enum logic [1:0] arb_state_t {IDLE, ACCESS, DONE};
  - typedef enum logic arb_owner_t {OWN_I, OWN_D}.
- One sub-module, ram_arb_starve_ctr: the saturating counter plus fetch-priority override. Its output is a single force_fetch bit.

## Test plan
- Fetch only, i_addr=0x10, ram_rdata=0xDEADBEEF, no busy -> i_ack high at N+2 with i_rdata=0xDEADBEEF; ram_wen never asserted.
- Data write d_addr=0x20, d_wdata=0x12345678 -> ram_wen=1 at N+1 only with ram_addr=0x20; d_ack at N+2; a following read of 0x20 returns 0x12345678.
- ram_busy held for 3 cycles during ACCESS -> ram_wen stays 0 throughout; ack arrives at N+5.
- i_req held while d_ren is held continuously, STARVE_LIMIT=4 -> 4 data acks, then 1 fetch ack, then the pattern repeats.
- Simultaneous i_req and d_wen in IDLE with starve_cnt=0 -> data granted first; fetch ack 3 cycles after d_ack.
- nRst pulsed during ACCESS of a write -> no ram_wen, no ack; all outputs 0; FSM in IDLE.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types for the fetch/data RAM arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

    // Width of the starvation counter; STARVE_LIMIT must fit (1..7).
    localparam int unsigned CNT_W = 3;

endpackage

// File: rtl/ram_arb_starve_ctr.sv
// Saturating count of data grants made while fetch waits; raises force_fetch at the limit.
// Latency: force_fetch is combinational from the registered count and i_req.
// Backpressure: none; the count only moves on grants or on an idle cycle with no fetch.
// Ports: clk/nRst; in_idle (arbiter in IDLE), i_req, d_grant, i_grant; force_fetch out.
module ram_arb_starve_ctr
    import ram_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic nRst,
    input  logic in_idle,
    input  logic i_req,
    input  logic d_grant,
    input  logic i_grant,
    output logic force_fetch
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            starve_cnt <= '0;
        end else if (i_grant || (in_idle && !i_req)) begin
            starve_cnt <= '0;
        end else if (d_grant && i_req && (starve_cnt < LIMIT)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Once the limit is reached, a waiting fetch wins the next idle slot.
    assign force_fetch = i_req && (starve_cnt == LIMIT);

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port word RAM between fetch (read-only) and load/store; data wins unless fetch is starved.
// Latency: request seen in IDLE at N, RAM access at N+1, ack + rdata at N+2; one access per 3 cycles peak.
// Backpressure: ram_busy stalls in ACCESS (one cycle per busy cycle); requesters hold req until their ack.
// Ports: i_req/i_addr -> i_rdata/i_ack; d_ren/d_wen/d_addr/d_wdata -> d_rdata/d_ack;
//        ram_wen/ram_addr/ram_wdata out, ram_rdata/ram_busy in.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    input  logic        d_ren,
    input  logic        d_wen,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        ram_wen,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    input  logic        ram_busy
);

    arb_state_t  state, next_state;
    arb_owner_t  own_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        wr_q;
    logic [31:0] i_rdata_q;
    logic [31:0] d_rdata_q;

    logic in_idle;
    logic force_fetch;
    logic d_grant;
    logic i_grant;
    logic access_go;

    assign in_idle   = (state == IDLE);
    assign d_grant   = in_idle && (d_ren || d_wen) && !force_fetch;
    assign i_grant   = in_idle && i_req && !d_grant;
    assign access_go = (state == ACCESS) && !ram_busy;

    ram_arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk         (clk),
        .nRst        (nRst),
        .in_idle     (in_idle),
        .i_req       (i_req),
        .d_grant     (d_grant),
        .i_grant     (i_grant),
        .force_fetch (force_fetch)
    );

    // State register.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (d_grant || i_grant) next_state = ACCESS;
            ACCESS:  if (!ram_busy)          next_state = DONE;
            DONE:                            next_state = IDLE;
            default:                         next_state = IDLE;
        endcase
    end

    // Outputs decoded from state; wen only on the single non-busy ACCESS cycle of a write.
    always_comb begin
        ram_wen = 1'b0;
        i_ack   = 1'b0;
        d_ack   = 1'b0;
        if (access_go && wr_q) begin
            ram_wen = 1'b1;
        end
        if (state == DONE) begin
            i_ack = (own_q == OWN_I);
            d_ack = (own_q == OWN_D);
        end
    end

    // Request latch and read-data capture. The latch only moves on a grant, so
    // ram_addr/ram_wdata hold their last values outside ACCESS.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            own_q     <= OWN_I;
            addr_q    <= '0;
            wdata_q   <= '0;
            wr_q      <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            if (d_grant) begin
                own_q   <= OWN_D;
                addr_q  <= d_addr;
                wdata_q <= d_wdata;
                wr_q    <= d_wen;          // ren+wen together is a write
            end else if (i_grant) begin
                own_q   <= OWN_I;
                addr_q  <= i_addr;
                wr_q    <= 1'b0;
            end
            if (access_go) begin
                if (wr_q) begin
                    d_rdata_q <= '0;       // writes return zero read data
                end else if (own_q == OWN_I) begin
                    i_rdata_q <= ram_rdata;
                end else begin
                    d_rdata_q <= ram_rdata;
                end
            end
        end
    end

    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: directed requests push expected acks/writes, negedge monitors pop and compare.
module tb_ram_arbiter;
    import ram_arb_pkg::*;

    logic        clk = 1'b0;
    logic        nRst = 1'b0;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        d_ren;
    logic        d_wen;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        ram_wen;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        ram_busy;

    always #5 clk = ~clk;

    ram_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk       (clk),
        .nRst      (nRst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_ack     (i_ack),
        .d_ren     (d_ren),
        .d_wen     (d_wen),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ack     (d_ack),
        .ram_wen   (ram_wen),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .ram_busy  (ram_busy)
    );

    // Simple word RAM model with combinational read.
    logic [31:0] mem [0:63];
    initial begin
        for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
        mem[4]  <= 32'hDEADBEEF;   // 0x10
        mem[5]  <= 32'h11112222;   // 0x14
        mem[13] <= 32'h5555AAAA;   // 0x34
    end
    always @(posedge clk) if (ram_wen) mem[ram_addr[7:2]] <= ram_wdata;
    assign ram_rdata = mem[ram_addr[7:2]];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic is_d; logic [31:0] data; int cyc; } ack_t;
    typedef struct { int cyc; logic [31:0] addr; logic [31:0] data; } wr_t;
    ack_t ack_q[$];
    wr_t  wr_q[$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    // Ack monitor.
    always @(negedge clk) begin : ack_mon
        ack_t e;
        if (i_ack || d_ack) begin
            if (ack_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_ack @cycle %0d: i_ack=%b d_ack=%b, expected no ack", cyc, i_ack, d_ack);
            end else begin
                e = ack_q.pop_front();
                check("ack_owner", {31'd0, d_ack}, {31'd0, e.is_d});
                check("ack_exclusive", {31'd0, i_ack & d_ack}, 32'd0);
                check("ack_rdata", d_ack ? d_rdata : i_rdata, e.data);
                check("ack_cycle", cyc, e.cyc);
            end
        end
    end

    // RAM write monitor.
    always @(negedge clk) begin : wr_mon
        wr_t w;
        if (ram_wen) begin
            if (wr_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_ram_wen @cycle %0d: addr 0x%08h data 0x%08h, expected no write", cyc, ram_addr, ram_wdata);
            end else begin
                w = wr_q.pop_front();
                check("wen_cycle", cyc, w.cyc);
                check("wen_addr", ram_addr, w.addr);
                check("wen_wdata", ram_wdata, w.data);
                check("wen_not_busy", {31'd0, ram_busy}, 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [31:0] a);
        int n = 0;
        i_req  = 1'b1;
        i_addr = a;
        while (!i_ack && n < 50) begin
            tick();
            n++;
        end
        if (!i_ack) begin
            n_chk++;
            n_fail++;
            $display("FAIL fetch_timeout addr 0x%08h: got no i_ack, required one within 50 cycles", a);
        end
        i_req = 1'b0;
        tick();
    endtask

    task automatic do_data(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] wd);
        int n = 0;
        d_wen   = wr;
        d_ren   = rd;
        d_addr  = a;
        d_wdata = wd;
        while (!d_ack && n < 50) begin
            tick();
            n++;
        end
        if (!d_ack) begin
            n_chk++;
            n_fail++;
            $display("FAIL data_timeout addr 0x%08h: got no d_ack, required one within 50 cycles", a);
        end
        d_wen = 1'b0;
        d_ren = 1'b0;
        tick();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running at 200000 time units, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int t0;
        logic [31:0] da [0:3];
        logic [31:0] dd [0:3];
        da[0] = 32'h20; dd[0] = 32'h12345678;
        da[1] = 32'h24; dd[1] = 32'hA5A50001;
        da[2] = 32'h28; dd[2] = 32'hCAFE0003;
        da[3] = 32'h30; dd[3] = 32'h0BADF00D;

        i_req = 1'b0; i_addr = '0;
        d_ren = 1'b0; d_wen = 1'b0; d_addr = '0; d_wdata = '0;
        ram_busy = 1'b0;
        nRst = 1'b0;
        repeat (2) tick();

        // Reset state.
        check("rst_i_ack", {31'd0, i_ack}, 32'd0);
        check("rst_d_ack", {31'd0, d_ack}, 32'd0);
        check("rst_ram_wen", {31'd0, ram_wen}, 32'd0);
        check("rst_i_rdata", i_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        check("rst_ram_addr", ram_addr, 32'd0);
        check("rst_ram_wdata", ram_wdata, 32'd0);
        nRst = 1'b1;
        repeat (2) tick();

        // Fetch only.
        t0 = cyc;
        ack_q.push_back('{1'b0, 32'hDEADBEEF, t0 + 2});
        do_fetch(32'h10);

        // Data write then read-back.
        t0 = cyc;
        wr_q.push_back('{t0 + 1, 32'h20, 32'h12345678});
        ack_q.push_back('{1'b1, 32'h0, t0 + 2});
        do_data(1'b1, 1'b0, 32'h20, 32'h12345678);
        t0 = cyc;
        ack_q.push_back('{1'b1, 32'h12345678, t0 + 2});
        do_data(1'b0, 1'b1, 32'h20, 32'h0);

        // ren and wen together: a write, d_rdata returns 0.
        t0 = cyc;
        wr_q.push_back('{t0 + 1, 32'h24, 32'hA5A50001});
        ack_q.push_back('{1'b1, 32'h0, t0 + 2});
        do_data(1'b1, 1'b1, 32'h24, 32'hA5A50001);

        // Three busy cycles during ACCESS.
        t0 = cyc;
        wr_q.push_back('{t0 + 4, 32'h28, 32'hCAFE0003});
        ack_q.push_back('{1'b1, 32'h0, t0 + 5});
        ram_busy = 1'b1;
        fork
            do_data(1'b1, 1'b0, 32'h28, 32'hCAFE0003);
            begin
                repeat (4) tick();
                ram_busy = 1'b0;
            end
        join
        t0 = cyc;
        ack_q.push_back('{1'b1, 32'hCAFE0003, t0 + 2});
        do_data(1'b0, 1'b1, 32'h28, 32'h0);

        // Simultaneous fetch and write: data first, fetch ack 3 cycles after d_ack.
        t0 = cyc;
        wr_q.push_back('{t0 + 1, 32'h30, 32'h0BADF00D});
        ack_q.push_back('{1'b1, 32'h0, t0 + 2});
        ack_q.push_back('{1'b0, 32'h11112222, t0 + 5});
        fork
            do_fetch(32'h14);
            do_data(1'b1, 1'b0, 32'h30, 32'h0BADF00D);
        join

        // Starvation: 4 data acks, 1 fetch ack, repeated.
        t0 = cyc;
        for (int k = 0; k < 10; k++) begin
            if (k == 4)      ack_q.push_back('{1'b0, 32'hDEADBEEF, t0 + 2 + 3 * k});
            else if (k == 9) ack_q.push_back('{1'b0, 32'h11112222, t0 + 2 + 3 * k});
            else             ack_q.push_back('{1'b1, dd[(k < 4) ? k : k - 5], t0 + 2 + 3 * k});
        end
        fork
            begin
                do_fetch(32'h10);
                do_fetch(32'h14);
            end
            begin
                for (int j = 0; j < 8; j++) do_data(1'b0, 1'b1, da[j % 4], 32'h0);
            end
        join

        // Reset during ACCESS of a write (held there by ram_busy).
        ram_busy = 1'b1;
        d_wen    = 1'b1;
        d_addr   = 32'h34;
        d_wdata  = 32'h77778888;
        repeat (2) tick();
        nRst  = 1'b0;
        d_wen = 1'b0;
        #1;
        check("midrst_ram_wen", {31'd0, ram_wen}, 32'd0);
        check("midrst_i_ack", {31'd0, i_ack}, 32'd0);
        check("midrst_d_ack", {31'd0, d_ack}, 32'd0);
        check("midrst_i_rdata", i_rdata, 32'd0);
        check("midrst_d_rdata", d_rdata, 32'd0);
        check("midrst_ram_addr", ram_addr, 32'd0);
        check("midrst_ram_wdata", ram_wdata, 32'd0);
        tick();
        nRst     = 1'b1;
        ram_busy = 1'b0;
        repeat (3) tick();
        // FSM back in IDLE and the abandoned write never landed.
        t0 = cyc;
        ack_q.push_back('{1'b1, 32'h5555AAAA, t0 + 2});
        do_data(1'b0, 1'b1, 32'h34, 32'h0);

        repeat (3) tick();
        check("ack_queue_drained", ack_q.size(), 32'd0);
        check("wr_queue_drained", wr_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
